// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder built from a single 4-bit ripple-carry slice.
// Each clock the slice adds one nibble of A and B, least significant nibble first.
// A registered carry links each nibble to the next one.
// The 4-bit slice (ripplecarry_ckt) lives in this same file, so the design has
// no outside dependencies.

// Single-bit full adder used to build the 4-bit ripple slice.
module rc_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

// 4-bit ripple-carry adder with scalar bit ports.
module ripplecarry_ckt (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic C_in,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic C_out
);

  logic [3:0] av;
  logic [3:0] bv;
  logic [3:0] sv;
  logic [4:0] cv;

  // Pack the scalar operand bits and unpack the sum bits.
  always_comb begin
    av    = {a3, a2, a1, a0};
    bv    = {b3, b2, b1, b0};
    cv[0] = C_in;
    S0    = sv[0];
    S1    = sv[1];
    S2    = sv[2];
    S3    = sv[3];
    C_out = cv[4];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      rc_full_adder u_fa (
        .x  (av[gi]),
        .y  (bv[gi]),
        .ci (cv[gi]),
        .s  (sv[gi]),
        .co (cv[gi+1])
      );
    end
  endgenerate

endmodule

// Sequencer that feeds ripplecarry_ckt one nibble per clock.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out
);

  localparam int W  = 4 * NIBBLES;
  // The counter only has to reach NIBBLES-1. It is kept at least one bit wide
  // so that it is still a real signal when NIBBLES is 1.
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    acc_sh_q, acc_sh_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;

  logic [3:0]      rc_s;
  logic            rc_cout;
  logic [W-1:0]    a_shr;
  logic [W-1:0]    b_shr;
  logic [W-1:0]    acc_ins;
  logic            last_nib;

  // The slice always sees the low nibble of each shift register and the
  // registered carry.
  ripplecarry_ckt u_rc (
    .a0    (a_sh_q[0]),
    .a1    (a_sh_q[1]),
    .a2    (a_sh_q[2]),
    .a3    (a_sh_q[3]),
    .b0    (b_sh_q[0]),
    .b1    (b_sh_q[1]),
    .b2    (b_sh_q[2]),
    .b3    (b_sh_q[3]),
    .C_in  (carry_q),
    .S0    (rc_s[0]),
    .S1    (rc_s[1]),
    .S2    (rc_s[2]),
    .S3    (rc_s[3]),
    .C_out (rc_cout)
  );

  // The shifted operand values and the accumulator with the new nibble added.
  // A single-nibble build has no upper bits to shift down, so it gets its own
  // branch.
  generate
    if (NIBBLES == 1) begin : g_one
      assign a_shr   = '0;
      assign b_shr   = '0;
      assign acc_ins = rc_s;
    end else begin : g_many
      assign a_shr   = {4'b0000, a_sh_q[W-1:4]};
      assign b_shr   = {4'b0000, b_sh_q[W-1:4]};
      assign acc_ins = {rc_s, acc_sh_q[W-1:4]};
    end
  endgenerate

  assign last_nib = (cnt_q == CNT_LAST);

  // State register and datapath registers, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_sh_q <= acc_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
    end
  end

  // Next state: accept in IDLE, run NIBBLES cycles, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The result registers load only on the last nibble,
  // so partial sums never reach the outputs.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_sh_d = acc_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_sh_d = acc_ins;
        a_sh_d   = a_shr;
        b_sh_d   = b_shr;
        carry_d  = rc_cout;
        cnt_d    = cnt_q + CW'(1);
        if (last_nib) begin
          sum_d   = acc_ins;
          c_out_d = rc_cout;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the state and the result registers.
  always_comb begin
    busy  = (state_q == RUN) || (state_q == DONE);
    done  = (state_q == DONE);
    sum   = sum_q;
    c_out = c_out_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder with NIBBLES=4: directed cases followed by random additions.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int total = 0;
  int bad   = 0;

  // Expected contents of the result registers, held between completions.
  logic [W:0] held_q = '0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a plain wide addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // One full transaction. It checks the latency and that the outputs hold
  // their old value until done, then checks the result.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic ci);
    logic [W:0] exp;
    int lat;
    exp = ref_add(xa, xb, ci);
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; c_in = ci;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; c_in = $urandom;
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 3 * N; k++) begin
      if (done) break;
      chk({tag, "_hold"}, {15'd0, c_out, sum}, {15'd0, held_q});
      @(negedge clk);
      lat = k;
    end
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, exp[W-1:0]});
    chk({tag, "_cout"}, {31'd0, c_out}, {31'd0, exp[W]});
    held_q = exp;
    @(negedge clk);
    chk({tag, "_done_fall"}, {30'd0, busy, done}, 32'd0);
    $display("op %s a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d", tag, xa, xb, ci, sum, c_out);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;
    logic rc;

    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", {14'd0, busy, done, c_out, sum}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {14'd0, busy, done, c_out, sum}, 32'd0);

    run_op("basic",   16'h1234, 16'h4321, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0);
    run_op("internib", 16'h000F, 16'h0001, 1'b0);
    run_op("carryin", 16'h0006, 16'h0003, 1'b1);

    // Start pulses during RUN and DONE must be ignored.
    @(negedge clk);
    start = 1'b1; a = 16'h0100; b = 16'h0200; c_in = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 3 * N; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (done) ndone++;
    chk("ign_sum", {16'd0, sum}, 32'h0300);
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    @(negedge clk);
    chk("ign_in_done", {30'd0, busy, done}, 32'd0);
    chk("ign_one_done", ndone, 1);
    held_q = 17'h00300;
    // Start is still high in this IDLE cycle, so this edge accepts it.
    @(negedge clk);
    start = 1'b0;
    chk("idle_accept", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 3 * N; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("idle_accept_sum", {15'd0, c_out, sum}, 32'h2222);
    held_q = 17'h02222;
    @(negedge clk);
    $display("op ignore_start sum=%04h", sum);

    // Reset during RUN aborts the addition and clears the outputs.
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", {14'd0, busy, done, c_out, sum}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == 1) rst_n = 1'b1;
    end
    chk("rst_no_done", ndone, 0);
    held_q = '0;
    $display("op reset_mid_run busy=%0d sum=%04h", busy, sum);
    run_op("after_rst", 16'h0002, 16'h0003, 1'b0);

    // Random additions checked against the reference.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op("rand", ra, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: stop the run if it never reaches the summary.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
